// File: rtl/register_file_dual_pkg.sv
// Shared types and constants for the dual-write, quad-read GPR file.
// Optional write-through bypass is selected by the REGFILE_BYPASS_EN macro.
package register_file_dual_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

  localparam int unsigned REG_ZERO       = 0;
  localparam int unsigned NUM_READ_PORTS = 4;

endpackage

// File: rtl/register_file_dual_if.sv
// Writeback/decode-side bundle of the GPR file: two write lanes, four read ports.
// Bypass behaviour on the read ports depends on REGFILE_BYPASS_EN.
interface register_file_dual_if
  import register_file_dual_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  wr_en_m;
  logic [ADDR_WIDTH-1:0] wr_dest_m;
  logic [DATA_WIDTH-1:0] wr_data_m;
  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] wr_dest_s;
  logic [DATA_WIDTH-1:0] wr_data_s;

  logic [ADDR_WIDTH-1:0] rd_addr_0;
  logic [ADDR_WIDTH-1:0] rd_addr_1;
  logic [ADDR_WIDTH-1:0] rd_addr_2;
  logic [ADDR_WIDTH-1:0] rd_addr_3;
  logic [DATA_WIDTH-1:0] rd_data_0;
  logic [DATA_WIDTH-1:0] rd_data_1;
  logic [DATA_WIDTH-1:0] rd_data_2;
  logic [DATA_WIDTH-1:0] rd_data_3;

  modport master (
    output wr_en_m, wr_dest_m, wr_data_m,
    output wr_en_s, wr_dest_s, wr_data_s,
    output rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
    input  rd_data_0, rd_data_1, rd_data_2, rd_data_3
  );

  modport slave (
    input  wr_en_m, wr_dest_m, wr_data_m,
    input  wr_en_s, wr_dest_s, wr_data_s,
    input  rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
    output rd_data_0, rd_data_1, rd_data_2, rd_data_3
  );

endinterface

// File: rtl/register_file_dual_read_port.sv
// One asynchronous read port: zero register, then (REGFILE_BYPASS_EN) slave/master
// write-through bypass, then the stored word.
module regfile_read_port
  import register_file_dual_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en_m,
  input  logic [ADDR_WIDTH-1:0] wr_dest_m,
  input  logic [DATA_WIDTH-1:0] wr_data_m,
  input  logic                  wr_en_s,
  input  logic [ADDR_WIDTH-1:0] wr_dest_s,
  input  logic [DATA_WIDTH-1:0] wr_data_s,
  input  logic [DATA_WIDTH-1:0] stored,
  output logic [DATA_WIDTH-1:0] data
);

`ifdef REGFILE_BYPASS_EN
  // Bypass is suppressed during reset: those writes are discarded at the edge.
  always_comb begin
    data = stored;
    if (addr == ADDR_WIDTH'(REG_ZERO)) begin
      data = '0;
    end else if (!rst && wr_en_s && (wr_dest_s == addr)) begin
      data = wr_data_s;
    end else if (!rst && wr_en_m && (wr_dest_m == addr)) begin
      data = wr_data_m;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{rst, wr_en_m, wr_dest_m, wr_data_m,
                           wr_en_s, wr_dest_s, wr_data_s};

  always_comb begin
    data = stored;
    if (addr == ADDR_WIDTH'(REG_ZERO)) begin
      data = '0;
    end
  end
`endif

endmodule

// File: rtl/register_file_dual.sv
// Dual-write (master/slave writeback lanes), quad-read architectural GPR file.
// Same-cycle write-through to the read ports is enabled by REGFILE_BYPASS_EN.
module register_file_dual
  import register_file_dual_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic                clk,
  input logic                rst,
  register_file_dual_if.slave bus
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

  // Index 0 has no storage; it is supplied as constant zero by the read ports.
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

  logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ_PORTS];
  logic [DATA_WIDTH-1:0] rd_data [NUM_READ_PORTS];
  logic [DATA_WIDTH-1:0] stored  [NUM_READ_PORTS];

  assign rd_addr[0] = bus.rd_addr_0;
  assign rd_addr[1] = bus.rd_addr_1;
  assign rd_addr[2] = bus.rd_addr_2;
  assign rd_addr[3] = bus.rd_addr_3;

  assign bus.rd_data_0 = rd_data[0];
  assign bus.rd_data_1 = rd_data[1];
  assign bus.rd_data_2 = rd_data[2];
  assign bus.rd_data_3 = rd_data[3];

  // Slave lane is the younger instruction, so it wins a same-destination collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (bus.wr_en_s && (bus.wr_dest_s == ADDR_WIDTH'(i))) begin
          regs[i] <= bus.wr_data_s;
        end else if (bus.wr_en_m && (bus.wr_dest_m == ADDR_WIDTH'(i))) begin
          regs[i] <= bus.wr_data_m;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
      stored[p] = '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (rd_addr[p] == ADDR_WIDTH'(i)) begin
          stored[p] = regs[i];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    regfile_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port (
      .rst      (rst),
      .addr     (rd_addr[p]),
      .wr_en_m  (bus.wr_en_m),
      .wr_dest_m(bus.wr_dest_m),
      .wr_data_m(bus.wr_data_m),
      .wr_en_s  (bus.wr_en_s),
      .wr_dest_s(bus.wr_dest_s),
      .wr_data_s(bus.wr_data_s),
      .stored   (stored[p]),
      .data     (rd_data[p])
    );
  end

endmodule

// File: tb/tb_register_file_dual.sv
// Self-checking bench for register_file_dual: directed plan steps, then random traffic
// against an array model. Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_register_file_dual;
  import register_file_dual_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_dual_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_file_dual #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model [NR];

  // Architectural view: index 0 is zero; a live, non-reset write is seen
  // immediately when bypass exists (younger slave lane first).
  function automatic logic [DW-1:0] expect_rd(logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYPASS && !rst) begin
      if (bus.wr_en_s && bus.wr_dest_s == a) return bus.wr_data_s;
      if (bus.wr_en_m && bus.wr_dest_m == a) return bus.wr_data_m;
    end
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    #1;
    check({tag, "_p0"}, bus.rd_data_0, expect_rd(bus.rd_addr_0));
    check({tag, "_p1"}, bus.rd_data_1, expect_rd(bus.rd_addr_1));
    check({tag, "_p2"}, bus.rd_data_2, expect_rd(bus.rd_addr_2));
    check({tag, "_p3"}, bus.rd_data_3, expect_rd(bus.rd_addr_3));
  endtask

  // Commit in program order: master first, then the younger slave overwrites.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) model[i] = '0;
    end else begin
      if (bus.wr_en_m && bus.wr_dest_m != 0) model[bus.wr_dest_m] = bus.wr_data_m;
      if (bus.wr_en_s && bus.wr_dest_s != 0) model[bus.wr_dest_s] = bus.wr_data_s;
    end
    #1;
  endtask

  task automatic set_wr(input logic em, input logic [AW-1:0] dm, input logic [DW-1:0] xm,
                        input logic es, input logic [AW-1:0] ds, input logic [DW-1:0] xs);
    bus.wr_en_m = em; bus.wr_dest_m = dm; bus.wr_data_m = xm;
    bus.wr_en_s = es; bus.wr_dest_s = ds; bus.wr_data_s = xs;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    bus.rd_addr_0 = a0; bus.rd_addr_1 = a1; bus.rd_addr_2 = a2; bus.rd_addr_3 = a3;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = 'x;
    rst = 1'b1;
    set_wr(1'b0, '0, '0, 1'b0, '0, '0);
    set_rd(0, 0, 0, 0);
    step();
    rst = 1'b0;

    // Reset state
    set_rd(1, 5, 17, 31);
    check_reads("reset_state");

    // Reset clears a written register
    set_wr(1'b1, 5, 32'hDEADBEEF, 1'b0, '0, '0);
    step();
    set_wr(1'b0, '0, '0, 1'b0, '0, '0);
    set_rd(5, 5, 5, 5);
    #1 check("r5_written", bus.rd_data_0, 32'hDEADBEEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("reset_r5_p0", bus.rd_data_0, 32'h0);
    check("reset_r5_p1", bus.rd_data_1, 32'h0);
    check("reset_r5_p2", bus.rd_data_2, 32'h0);
    check("reset_r5_p3", bus.rd_data_3, 32'h0);

    // Zero register via master, then slave
    set_wr(1'b1, 0, 32'hFFFFFFFF, 1'b0, '0, '0);
    set_rd(0, 0, 0, 0);
    check_reads("zero_m_same");
    step();
    set_wr(1'b0, '0, '0, 1'b0, '0, '0);
    #1 check("zero_m_next", bus.rd_data_0, 32'h0);
    set_wr(1'b0, '0, '0, 1'b1, 0, 32'hFFFFFFFF);
    step();
    set_wr(1'b0, '0, '0, 1'b0, '0, '0);
    #1 check("zero_s_next", bus.rd_data_3, 32'h0);

    // Dual write, distinct registers
    set_wr(1'b1, 3, 32'h11111111, 1'b1, 4, 32'h22222222);
    set_rd(3, 4, 4, 3);
    check_reads("dual_same");
    step();
    set_wr(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    check("dual_r3", bus.rd_data_0, 32'h11111111);
    check("dual_r4", bus.rd_data_1, 32'h22222222);

    // Collision on r7: slave wins
    set_wr(1'b1, 7, 32'hAAAA0000, 1'b1, 7, 32'h0000BBBB);
    set_rd(7, 7, 7, 7);
    #1 check("collide_same", bus.rd_data_0, BYPASS ? 32'h0000BBBB : 32'h0);
    check_reads("collide_same_model");
    step();
    set_wr(1'b0, '0, '0, 1'b0, '0, '0);
    #1 check("collide_next", bus.rd_data_2, 32'h0000BBBB);

    // Bypass timing on r9
    set_wr(1'b1, 9, 32'h5, 1'b0, '0, '0);
    step();
    set_wr(1'b1, 9, 32'h6, 1'b0, '0, '0);
    set_rd(0, 0, 9, 0);
    #1 check("bypass_same", bus.rd_data_2, BYPASS ? 32'h6 : 32'h5);
    step();
    set_wr(1'b0, '0, '0, 1'b0, '0, '0);
    #1 check("bypass_next", bus.rd_data_2, 32'h6);

    // Reset together with a write to r12
    set_wr(1'b0, '0, '0, 1'b1, 12, 32'hCAFE0012);
    step();
    rst = 1'b1;
    set_wr(1'b0, '0, '0, 1'b1, 12, 32'h12345678);
    set_rd(12, 12, 12, 12);
    #1 check("rst_write_same", bus.rd_data_1, 32'hCAFE0012);
    check_reads("rst_write_same_model");
    step();
    rst = 1'b0;
    set_wr(1'b0, '0, '0, 1'b0, '0, '0);
    #1 check("rst_write_next", bus.rd_data_1, 32'h0);

    // Random traffic, destinations concentrated on a few registers to force collisions
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      set_wr(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
             DW'($urandom));
      set_rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
             AW'($urandom), AW'($urandom_range(0, 7)));
      check_reads("random");
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file_dual.md
Name: register_file_dual

Overview:
- Architectural GPR file that consumes the writeback stage's outputs: write enable, destination and data.
- Two write ports take the master and slave writeback lanes of the dual-issue pipe; the slave lane is the younger instruction.
- Four asynchronous read ports serve decode/issue, two operands per lane.
- Internal write-through bypass: a value written in cycle N is visible on the read ports in cycle N.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers, index 0 hardwired to zero

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
wr_en_m  input  1  master lane write enable (writeback reg_write_en)
wr_dest_m  input  ADDR_WIDTH  master lane destination index
wr_data_m  input  DATA_WIDTH  master lane write data
wr_en_s  input  1  slave lane write enable
wr_dest_s  input  ADDR_WIDTH  slave lane destination index
wr_data_s  input  DATA_WIDTH  slave lane write data
rd_addr_0..rd_addr_3  input  ADDR_WIDTH each  read indices (0/1 master operands, 2/3 slave operands)
rd_data_0..rd_data_3  output  DATA_WIDTH each  read data

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Storage: registers 1..2**ADDR_WIDTH-1 are flops; register 0 has no storage.
- Reset: on a rising edge with rst=1, all stored registers become 0 and writes in that cycle are discarded.
  - Reads are combinational, so every rd_data_* reads 0 from the cycle after the reset edge onward.
  - During rst=1 the bypass is gated off, so rd_data_* never reflects a discarded write.
- Write: on a rising edge with rst=0, a port with wr_en=1 and wr_dest!=0 updates its register.
  - Writes to index 0 are ignored.
- Same-destination collision: if both ports are enabled with equal nonzero dest, the slave data is stored (younger wins).
- Different destinations: both writes commit in the same edge.
- Read: rd_data_k is combinational from rd_addr_k. Priority, highest first:
  - rd_addr_k==0 → 0.
  - Slave write enabled and dest matches → wr_data_s.
  - Master write enabled and dest matches → wr_data_m.
  - Otherwise → stored value.
- Latency: write-to-read visibility is 0 cycles with bypass, 1 cycle after the edge without bypass.
- Width rules: no sign or zero extension; data is passed verbatim at DATA_WIDTH.
- No handshake; the block accepts a write every cycle on both ports and never stalls.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through bypass as described above.
- Undefined: read ports return stored values only.
  - A same-cycle write is visible only after the clock edge.
  - The pipeline must supply its own forwarding.
  - Collision and zero-register rules are unchanged.

Decomposition:
- Shared package holds:
  - reg_addr_t (ADDR_WIDTH-bit) and reg_data_t (DATA_WIDTH-bit) typedefs.
  - Constant REG_ZERO = 0.
  - Constant NUM_READ_PORTS = 4.
- One natural sub-module, regfile_read_port: one address in, both write ports plus the array word in, data out.
  - Implements the zero/bypass priority; instantiated 4 times.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst one cycle, then read r5 on all four ports → 0x00000000.
- Zero register: wr_en_m=1, dest=0, data=0xFFFFFFFF; next cycle read r0 → 0. Same result via the slave port.
- Dual write, distinct regs: master r3=0x11111111, slave r4=0x22222222 same cycle; next cycle rd_addr_0=3, rd_addr_1=4 → 0x11111111, 0x22222222.
- Collision: master r7=0xAAAA0000, slave r7=0x0000BBBB same cycle.
  - Same-cycle read of r7 → 0x0000BBBB with bypass.
  - Next cycle → 0x0000BBBB in both builds.
- Bypass timing: r9 holds 0x5; write r9=0x6 via master while rd_addr_2=9.
  - REGFILE_BYPASS_EN defined → 0x6 in the same cycle.
  - Undefined → 0x5, then 0x6 after the edge.
- Reset mid-write: rst=1 together with wr_en_s=1, dest=12, data=0x12345678.
  - Same-cycle read of r12 → stored value, no bypass.
  - After the edge, r12 → 0.
